// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the multiplexed seven-segment scanner.
//   seg_t     - 7-bit active-low segment vector {a,b,c,d,e,f,g}
//   SEG_BLANK - all segments off
//   SEG_LUT   - hex digit (0..F) to active-low segment pattern, entry n = digit n
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // Listed from F down to 0 so that SEG_LUT[n] is the pattern for digit n.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: combinational hex nibble to seven-segment pattern.
//   nibble - 4-bit hex value
//   seg    - active-low segment pattern {a,b,c,d,e,f,g}
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed N-digit seven-segment display controller.
//   CLK100      - system clock
//   resetn      - synchronous active-low reset
//   value_i     - hex value, nibble k shown on digit k (digit 0 rightmost)
//   digit_en_i  - per-digit enable (0 keeps that anode off)
//   dp_i        - per-digit decimal point request, active-high
//   blank_lz_i  - suppress leading zeros
//   bright_i    - brightness 0..15 (on-window is phases 0..bright of 16)
//   seg_o       - active-low segments {CA..CG}
//   dp_o        - active-low decimal point
//   an_o        - active-low anodes, at most one low
//   frame_o     - one-cycle pulse at the start of each frame
// All inputs are sampled only at the frame boundary, so a frame is always
// drawn from one consistent snapshot.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_LOG2 = 10
) (
    input  logic                    CLK100,
    input  logic                    resetn,
    input  logic [4*N_DIGITS-1:0]   value_i,
    input  logic [N_DIGITS-1:0]     digit_en_i,
    input  logic [N_DIGITS-1:0]     dp_i,
    input  logic                    blank_lz_i,
    input  logic [3:0]              bright_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [N_DIGITS-1:0]     an_o,
    output logic                    frame_o
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [REFRESH_LOG2-1:0] cnt_p0;
    logic [IDX_W-1:0]        idx_p0;
    logic [4*N_DIGITS-1:0]   sh_value_p0;
    logic [N_DIGITS-1:0]     sh_en_p0;
    logic [N_DIGITS-1:0]     sh_dp_p0;
    logic                    sh_blank_p0;
    logic [3:0]              sh_bright_p0;

    logic                    wrap;
    logic                    last_digit;

    assign wrap       = &cnt_p0;
    assign last_digit = (idx_p0 == IDX_W'(N_DIGITS - 1));

    // Stage p0: slot counter, digit index and frame-synchronous shadow latch
    always_ff @(posedge CLK100) begin
        if (!resetn) begin
            cnt_p0       <= '0;
            idx_p0       <= '0;
            sh_value_p0  <= '0;
            sh_en_p0     <= '0;
            sh_dp_p0     <= '0;
            sh_blank_p0  <= 1'b0;
            sh_bright_p0 <= 4'd0;
        end else begin
            cnt_p0 <= cnt_p0 + REFRESH_LOG2'(1);
            if (wrap) begin
                if (last_digit) begin
                    idx_p0       <= '0;
                    sh_value_p0  <= value_i;
                    sh_en_p0     <= digit_en_i;
                    sh_dp_p0     <= dp_i;
                    sh_blank_p0  <= blank_lz_i;
                    sh_bright_p0 <= bright_i;
                end else begin
                    idx_p0 <= idx_p0 + IDX_W'(1);
                end
            end
        end
    end

    // hi_zero[k]: nibbles k..N_DIGITS-1 of the snapshot are all zero.
    logic [N_DIGITS-1:0] hi_zero;
    logic                acc;

    always_comb begin
        hi_zero = '0;
        acc     = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            acc        = acc & (sh_value_p0[4*k +: 4] == 4'd0);
            hi_zero[k] = acc;
        end
    end

    logic [3:0]          nib;
    seg_t                dec_seg;
    logic                blanked;
    logic [3:0]          phase;
    logic                an_on;
    seg_t                seg_next;
    logic [N_DIGITS-1:0] an_next;

    assign nib = sh_value_p0[idx_p0*4 +: 4];

    seg7_hex_decoder u_dec (
        .nibble (nib),
        .seg    (dec_seg)
    );

    // Digit 0 is never blanked, so a zero value still shows a single '0'.
    assign blanked  = sh_blank_p0 && (idx_p0 != '0) && hi_zero[idx_p0];
    assign seg_next = blanked ? SEG_BLANK : dec_seg;

    assign phase   = cnt_p0[REFRESH_LOG2-1 -: 4];
    assign an_on   = (phase <= sh_bright_p0) && sh_en_p0[idx_p0];
    assign an_next = an_on ? ~(N_DIGITS'(1) << idx_p0) : '1;

    logic [6:0]          seg_p1;
    logic                dp_p1;
    logic [N_DIGITS-1:0] an_p1;
    logic                frame_p1;

    // Stage p1: segments, dp and anodes registered together so they switch
    // on the same edge and never mix neighbouring digits
    always_ff @(posedge CLK100) begin
        if (!resetn) begin
            seg_p1   <= SEG_BLANK;
            dp_p1    <= 1'b1;
            an_p1    <= '1;
            frame_p1 <= 1'b0;
        end else begin
            seg_p1   <= seg_next;
            dp_p1    <= ~sh_dp_p0[idx_p0];
            an_p1    <= an_next;
            frame_p1 <= wrap && last_digit;
        end
    end

    assign seg_o   = seg_p1;
    assign dp_o    = dp_p1;
    assign an_o    = an_p1;
    assign frame_o = frame_p1;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (8 digits, 16-cycle slots).
module tb_seg7_scan_ctrl;

    localparam int N  = 8;
    localparam int R  = 4;
    localparam int S  = 1 << R;
    localparam int FR = N * S;

    logic        CLK100 = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] value_i = '0;
    logic [7:0]  digit_en_i = '0;
    logic [7:0]  dp_i = '0;
    logic        blank_lz_i = 1'b0;
    logic [3:0]  bright_i = '0;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [7:0]  an_o;
    logic        frame_o;

    seg7_scan_ctrl #(.N_DIGITS(N), .REFRESH_LOG2(R)) dut (
        .CLK100     (CLK100),
        .resetn     (resetn),
        .value_i    (value_i),
        .digit_en_i (digit_en_i),
        .dp_i       (dp_i),
        .blank_lz_i (blank_lz_i),
        .bright_i   (bright_i),
        .seg_o      (seg_o),
        .dp_o       (dp_o),
        .an_o       (an_o),
        .frame_o    (frame_o)
    );

    always #5 CLK100 = ~CLK100;

    int checks = 0;
    int errors = 0;

    logic [6:0] hex_ref [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: elapsed cycles since reset decide slot and digit.
    int          t = 0;
    bit          mok = 1'b0;
    logic [31:0] m_val;
    logic [7:0]  m_en, m_dp;
    logic        m_blk;
    logic [3:0]  m_br;
    logic [6:0]  e_seg;
    logic        e_dp, e_fr;
    logic [7:0]  e_an;

    initial forever begin
        @(posedge CLK100);
        if (!resetn) begin
            t = 0;
            m_val = '0; m_en = '0; m_dp = '0; m_blk = 1'b0; m_br = '0;
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 8'hFF; e_fr = 1'b0;
        end else begin
            int c, k, nib, phase;
            bit blank;
            c     = t % S;
            k     = (t / S) % N;
            nib   = (m_val >> (4 * k)) & 32'hF;
            blank = m_blk && (k > 0) && ((m_val >> (4 * k)) == 0);
            phase = c / (S / 16);
            e_seg = blank ? 7'h7F : hex_ref[nib];
            e_dp  = !m_dp[k];
            e_an  = (m_en[k] && (phase <= int'(m_br))) ? ~(8'd1 << k) : 8'hFF;
            e_fr  = ((t % FR) == FR - 1);
            if (e_fr) begin
                m_val = value_i; m_en = digit_en_i; m_dp = dp_i;
                m_blk = blank_lz_i; m_br = bright_i;
            end
            t++;
        end
        mok = 1'b1;
    end

    initial forever begin
        @(negedge CLK100);
        if (mok) begin
            chk("seg", {25'd0, seg_o}, {25'd0, e_seg});
            chk("dp", {31'd0, dp_o}, {31'd0, e_dp});
            chk("an", {24'd0, an_o}, {24'd0, e_an});
            chk("frame", {31'd0, frame_o}, {31'd0, e_fr});
            chk("one_hot_an", {31'd0, ($countones(~an_o) <= 1)}, 32'd1);
        end
    end

    task automatic wait_digit(input int k);
        int n = 0;
        do begin
            @(negedge CLK100);
            n++;
        end while (an_o[k] !== 1'b0 && n < 400);
        chk("wait_digit", {31'd0, an_o[k]}, 32'd0);
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge CLK100);
            n++;
        end while (frame_o !== 1'b1 && n < 300);
        chk("wait_frame", {31'd0, frame_o}, 32'd1);
    endtask

    initial begin
        int cnt, n;
        value_i    = 32'h1234_5678;
        digit_en_i = 8'hFF;
        bright_i   = 4'd15;
        repeat (5) @(negedge CLK100);
        resetn = 1'b1;
        repeat (2) @(negedge CLK100);
        chk("first_frame_seg", {25'd0, seg_o}, 32'b0000001);
        chk("first_frame_an", {24'd0, an_o}, 32'hFF);

        wait_frame();
        wait_digit(0);
        chk("d0_is_8", {25'd0, seg_o}, 32'b0000000);
        wait_digit(7);
        chk("d7_is_1", {25'd0, seg_o}, 32'b1001111);

        value_i = 32'h0000_00A5; blank_lz_i = 1'b1;
        wait_frame();
        wait_digit(0); chk("lz_d0_5", {25'd0, seg_o}, 32'b0100100);
        wait_digit(1); chk("lz_d1_A", {25'd0, seg_o}, 32'b0001000);
        wait_digit(2); chk("lz_d2_blank", {25'd0, seg_o}, 32'h7F);
        wait_digit(7); chk("lz_d7_blank", {25'd0, seg_o}, 32'h7F);

        value_i = 32'h0;
        wait_frame();
        wait_digit(0); chk("zero_d0", {25'd0, seg_o}, 32'b0000001);
        wait_digit(1); chk("zero_d1_blank", {25'd0, seg_o}, 32'h7F);

        blank_lz_i = 1'b0; bright_i = 4'd3; value_i = 32'h1234_5678;
        wait_frame();
        wait_digit(2);
        cnt = 1;
        repeat (S - 1) begin
            @(negedge CLK100);
            if (an_o[2] === 1'b0) cnt++;
        end
        chk("bright3_duty", cnt, 32'd4);

        bright_i = 4'd15; digit_en_i = 8'hFE; dp_i = 8'h01;
        wait_frame();
        n = 0; cnt = 0;
        do begin
            @(negedge CLK100);
            n++;
            if (an_o[0] === 1'b0) cnt++;
        end while (frame_o !== 1'b1 && n < 400);
        chk("frame_period", n, FR);
        chk("an0_never_low", cnt, 32'd0);

        digit_en_i = 8'hFF; dp_i = 8'h00; value_i = 32'h1111_1111;
        wait_frame();
        wait_digit(3);
        value_i = 32'h2222_2222;
        wait_digit(5); chk("midframe_old", {25'd0, seg_o}, 32'b1001111);
        wait_frame();
        wait_digit(5); chk("next_frame_new", {25'd0, seg_o}, 32'b0010010);

        repeat (3000) begin
            @(negedge CLK100);
            if ($urandom_range(0, 63) == 0) begin
                value_i    = $urandom >> $urandom_range(0, 31);
                digit_en_i = 8'($urandom);
                dp_i       = 8'($urandom);
                blank_lz_i = 1'($urandom);
                bright_i   = 4'($urandom);
            end
        end

        digit_en_i = 8'hFF; bright_i = 4'd15;
        wait_frame();
        wait_digit(4);
        resetn = 1'b0;
        @(posedge CLK100); #1;
        chk("rst_an_high", {24'd0, an_o}, 32'hFF);
        chk("rst_frame_low", {31'd0, frame_o}, 32'd0);
        chk("rst_seg_blank", {25'd0, seg_o}, 32'h7F);
        @(negedge CLK100);
        resetn = 1'b1;
        repeat (3) @(negedge CLK100);
        chk("post_rst_an_off", {24'd0, an_o}, 32'hFF);
        wait_frame();
        wait_digit(0);
        repeat (20) @(negedge CLK100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
